// File: rtl/decoder_pkg.sv
// Shared constants for the registered one-hot decoder:
// hold modes, FSM encoding and stretch counter sizing.
package decoder_pkg;

  localparam logic [1:0] MODE_PULSE   = 2'd0;
  localparam logic [1:0] MODE_LEVEL   = 2'd1;
  localparam logic [1:0] MODE_STRETCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    STR  = 2'd2
  } state_t;

  function automatic int cnt_width(input int stretch);
    return (stretch <= 2) ? 1 : $clog2(stretch);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decode with an out-of-range
// flag for indices at or beyond NUM_OUT.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot,
  output logic               out_of_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = (32'(sel) == 32'(i));
    end
    out_of_range = (32'(sel) >= 32'(NUM_OUT));
  end

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered one-hot decoder with valid/ready accept, pulse,
// level and stretch hold modes, and out-of-range error pulse.
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 2 ** SEL_W,
  parameter int STRETCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] q,
  output logic               out_valid,
  output logic               err
);

  localparam int CNT_W = cnt_width(STRETCH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STRETCH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] q_q, q_d;
  logic               err_q, err_d;
  logic               ov_q, ov_d;

  logic [NUM_OUT-1:0] dec_oh;
  logic               dec_oor;
  logic               accept;

  onehot_dec #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) u_dec (
    .sel         (sel),
    .onehot      (dec_oh),
    .out_of_range(dec_oor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready = en && (state_q != STR);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = IDLE;
      if (!dec_oor) begin
        unique case (1'b1)
          (mode == MODE_LEVEL):   state_d = HOLD;
          (mode == MODE_STRETCH): state_d = STR;
          default:                state_d = IDLE;
        endcase
      end
    end else if (state_q == STR && cnt_q == '0) begin
      state_d = IDLE;
    end
  end

  // Datapath: stretch counts down while q holds, HOLD keeps q.
  always_comb begin
    q_d   = '0;
    cnt_d = '0;
    err_d = 1'b0;
    if (!en) begin
      q_d = '0;
    end else if (accept) begin
      err_d = dec_oor;
      q_d   = dec_oor ? '0 : dec_oh;
      if (!dec_oor && mode == MODE_STRETCH) begin
        cnt_d = CNT_INIT;
      end
    end else begin
      unique case (state_q)
        HOLD:    q_d = q_q;
        STR: begin
          if (cnt_q != '0) begin
            q_d   = q_q;
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: q_d = '0;
      endcase
    end
    ov_d = |q_d;
  end

  assign q         = q_q;
  assign out_valid = ov_q;
  assign err       = err_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed vector and sequence checks for decoder_onehot_seq,
// covering a 2-bit instance and a 3-bit, 5-output instance.
module tb_decoder_onehot_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       in_valid;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic       rdy_a, rdy_b;
  logic [3:0] q_a;
  logic [4:0] q_b;
  logic       ov_a, ov_b, err_a, err_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(2), .STRETCH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy_a), .sel(sel_a),
    .q(q_a), .out_valid(ov_a), .err(err_a)
  );

  decoder_onehot_seq #(.SEL_W(3), .NUM_OUT(5), .STRETCH(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy_b), .sel(sel_b),
    .q(q_b), .out_valid(ov_b), .err(err_b)
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic [1:0] sel;
    logic [1:0] mode;
    logic       rdy;
    logic [3:0] q;
    logic       ov;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic e, logic v, logic [1:0] s, logic [1:0] m,
                     logic r, logic [3:0] eq, logic eov, logic eerr);
    vec_t t;
    t.en = e; t.vld = v; t.sel = s; t.mode = m;
    t.rdy = r; t.q = eq; t.ov = eov; t.err = eerr;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; in_valid = 1'b0;
    sel_a = '0; sel_b = '0;

    // Pulse back-to-back
    add(1, 1, 0, 0, 1, 4'b0001, 1, 0);
    add(1, 1, 1, 0, 1, 4'b0010, 1, 0);
    add(1, 1, 2, 0, 1, 4'b0100, 1, 0);
    add(1, 1, 3, 3, 1, 4'b1000, 1, 0);
    add(1, 0, 0, 0, 1, 4'b0000, 0, 0);
    // Level held, then replaced without gap, then en drop
    add(1, 1, 1, 1, 1, 4'b0010, 1, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 1, 4'b0010, 1, 0);
    add(1, 1, 3, 1, 1, 4'b1000, 1, 0);
    add(0, 0, 0, 0, 0, 4'b0000, 0, 0);
    add(1, 0, 0, 0, 1, 4'b0000, 0, 0);
    // Stretch of 4 with in_valid held, second accept after clear
    add(1, 1, 2, 2, 1, 4'b0100, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0100, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0100, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0100, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 1, 0, 1, 4'b0010, 1, 0);
    add(1, 0, 0, 0, 1, 4'b0000, 0, 0);

    #12;
    chk("rst_q", 32'(q_a), 0);
    chk("rst_ov", 32'(ov_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_rdy_en0", 32'(rdy_a), 0);
    do_reset();
    chk("post_rst_rdy", 32'(rdy_a), 1);

    foreach (vecs[i]) begin
      en = vecs[i].en; in_valid = vecs[i].vld;
      sel_a = vecs[i].sel; mode = vecs[i].mode;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(rdy_a), 32'(vecs[i].rdy));
      tick();
      chk($sformatf("v%0d_q", i), 32'(q_a), 32'(vecs[i].q));
      chk($sformatf("v%0d_ov", i), 32'(ov_a), 32'(vecs[i].ov));
      chk($sformatf("v%0d_err", i), 32'(err_a), 32'(vecs[i].err));
    end

    // en low on the 2nd stretch hold cycle
    en = 1'b1; in_valid = 1'b1; sel_a = 2'd2; mode = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("enlo_hold1_q", 32'(q_a), 32'b0100);
    tick();
    chk("enlo_hold2_q", 32'(q_a), 32'b0100);
    chk("enlo_hold2_rdy", 32'(rdy_a), 0);
    en = 1'b0;
    tick();
    chk("enlo_q", 32'(q_a), 0);
    chk("enlo_ov", 32'(ov_a), 0);
    en = 1'b1;
    #1;
    chk("enlo_rdy_back", 32'(rdy_a), 1);
    tick();
    chk("enlo_idle_q", 32'(q_a), 0);

    // Async reset mid-stretch
    in_valid = 1'b1; sel_a = 2'd2; mode = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("ars_pre_q", 32'(q_a), 32'b0100);
    #2;
    rst = 1'b1;
    #1;
    chk("ars_q", 32'(q_a), 0);
    chk("ars_ov", 32'(ov_a), 0);
    chk("ars_err", 32'(err_a), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ars_rdy", 32'(rdy_a), 1);

    // Out of range on the 5-output instance clears a level value
    tick();
    in_valid = 1'b1; sel_b = 3'd1; mode = 2'd1;
    tick();
    chk("oor_lvl_q", 32'(q_b), 32'b00010);
    chk("oor_lvl_err", 32'(err_b), 0);
    sel_b = 3'd6;
    tick();
    in_valid = 1'b0;
    chk("oor_q", 32'(q_b), 0);
    chk("oor_err", 32'(err_b), 1);
    chk("oor_ov", 32'(ov_b), 0);
    tick();
    chk("oor_err_clr", 32'(err_b), 0);
    chk("oor_q_idle", 32'(q_b), 0);
    in_valid = 1'b1; sel_b = 3'd4; mode = 2'd0;
    tick();
    in_valid = 1'b0;
    chk("oor_edge_q", 32'(q_b), 32'b10000);
    chk("oor_edge_err", 32'(err_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_seq.md
# decoder_onehot_seq

Parametrised, registered binary-to-one-hot decoder. It generalises the fixed 2-to-4 combinational decoder to SEL_W select bits and NUM_OUT outputs. It adds a valid/ready input handshake, three output-hold modes (pulse, level, stretch) and out-of-range detection. It sits between control logic issuing channel indices and per-channel enable/strobe consumers.

## Interface
- SEL_W, 2, select width; legal range 1..8.
- NUM_OUT, 2**SEL_W, number of one-hot outputs; legal range 2..2**SEL_W.
- STRETCH, 4, hold length in cycles for stretch mode; must be ≥1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low blocks accepts and clears outputs.
- mode  input  2  hold mode, sampled on accept: 0 = PULSE, 1 = LEVEL, 2 = STRETCH, 3 = reserved (behaves as PULSE).
- in_valid  input  1  sel is valid this cycle.
- in_ready  output  1  block can accept this cycle.
- sel  input  SEL_W  binary index to decode.
- q  output  NUM_OUT  one-hot (or all-zero) decoded output, registered.
- out_valid  output  1  high when q is nonzero.
- err  output  1  one-cycle pulse on accept of sel ≥ NUM_OUT.

## Operation
- States: IDLE, HOLD, STR.
- Accept: in_valid && in_ready.
- in_ready is combinational: en && (state != STR).
- Accept with sel < NUM_OUT:
  - q ← (1 << sel) and out_valid ← 1 on the next edge.
  - Next state by mode: PULSE → IDLE; LEVEL → HOLD; STRETCH → STR, with cnt ← STRETCH−1.
- Accept with sel ≥ NUM_OUT: q ← 0, out_valid ← 0, err ← 1 for one cycle, state ← IDLE.
- No accept, state IDLE: q ← 0.
- No accept, state HOLD: q held.
- STR:
  - cnt decrements each cycle while q is held.
  - When cnt == 0, the next edge sets q ← 0 and state ← IDLE.
  - STRETCH = 1 therefore behaves as PULSE, except in_ready is low for the one output cycle.
- en low:
  - Takes priority over everything.
  - Next edge: q ← 0, err ← 0, cnt ← 0, state ← IDLE, including mid-stretch.
  - in_ready is low while en is low.
- Accept in HOLD: the new value replaces the old one with no gap cycle. The mode for the new accept is freshly sampled.
- err is never asserted together with a nonzero q.
- Counter width: CNT_W = $clog2(STRETCH) with a minimum of 1. No wrap: the counter only ever counts down from STRETCH−1 to 0.

## Timing
- Reset (async assert, synchronous deassert observed at the next edge): q = 0, out_valid = 0, err = 0, cnt = 0, state = IDLE. in_ready then follows en.
- Latency: the accept edge produces q/out_valid/err one cycle later. There is no combinational path from sel to q.
- PULSE: back-to-back accepts every cycle give a different one-hot each cycle, at full throughput.
- STRETCH: q is high for exactly STRETCH cycles. in_ready is low for those same STRETCH cycles, so the next accept is possible on the cycle after q clears. Minimum accept-to-accept spacing is STRETCH+1 cycles.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.

## Structure
- Package decoder_pkg holds:
  - mode constants MODE_PULSE, MODE_LEVEL, MODE_STRETCH;
  - state encoding IDLE/HOLD/STR;
  - a function to compute CNT_W.
- Sub-module onehot_dec: purely combinational, parametrised SEL_W/NUM_OUT. It outputs the one-hot vector and an out_of_range flag. The top-level instantiates it once and registers its result.
- Top-level contents: state register, counter, handshake and output registers.

## Test plan
- Reset and idle: assert rst mid-stretch with sel=2 → q=0, err=0, out_valid=0 immediately; after release with en=1, in_ready=1.
- PULSE back-to-back (SEL_W=2): accept sel=0,1,2,3 on consecutive cycles → q=0001,0010,0100,1000 on the following cycles, then 0000.
- LEVEL: accept sel=1 in mode 1 → q=0010 held for 10 idle cycles; then accept sel=3 → q=1000 next cycle with no zero gap; then drop en → q=0000 next cycle.
- STRETCH with STRETCH=4: accept sel=2 → q=0100 for exactly 4 cycles and in_ready=0 for those 4 cycles. in_valid held high throughout is accepted on the cycle q clears, giving the second output one cycle later.
- Out of range (SEL_W=3, NUM_OUT=5): accept sel=6 → err=1 for one cycle with q=00000. A previous LEVEL value of q=00010 is cleared.
- en low mid-stretch: STRETCH=4, drop en on the 2nd hold cycle → q=0 next edge, state IDLE; re-raising en gives in_ready=1 immediately.
